// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD-to-binary converter.
// Digit constants are 4-bit typed so compares and subtracts stay width-exact.
package bcd_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam int         DIG_W      = 4;
    localparam logic [3:0] MAX_DIGIT  = 4'd9;
    localparam logic [3:0] ADJ_THRESH = 4'd8;
    localparam logic [3:0] ADJ_OFFSET = 4'd3;

endpackage

// File: rtl/bcd_to_bin_if.sv
// Request/result bundle for bcd_to_bin.
// Handshake: start is a request strobe taken only when busy=0; there is no back-pressure.
// done is the valid for bin_out/err and lasts exactly one cycle.
interface bcd_to_bin_if #(
    parameter int NDIG = 4,
    parameter int BW   = 14
);
    logic                start;
    logic [4*NDIG-1:0]   bcd_in;
    logic [BW-1:0]       bin_out;
    logic                busy;
    logic                done;
    logic                err;

    modport master (
        output start, bcd_in,
        input  bin_out, busy, done, err
    );

    modport slave (
        input  start, bcd_in,
        output bin_out, busy, done, err
    );
endinterface

// File: rtl/bcd_digit_adj.sv
// One digit of reverse double-dabble: a digit that reached 8+ after a right
// shift had a carry of 10 halved to 5, so subtract 3 to restore BCD.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [3:0] i_dig,
    output logic [3:0] o_dig
);
    assign o_dig = (i_dig >= ADJ_THRESH) ? (i_dig - ADJ_OFFSET) : i_dig;
endmodule

// File: rtl/bcd_to_bin.sv
// Iterative BCD-to-binary converter: one bit of reverse double-dabble per clock,
// BW cycles per conversion, illegal digits rejected in one cycle.
module bcd_to_bin
    import bcd_pkg::*;
#(
    parameter int NDIG = 4,
    parameter int BW   = 14
) (
    input  logic         clk,
    input  logic         clr,
    bcd_to_bin_if.slave  bus,
    output state_e       o_state
);
    localparam int CNT_W = $clog2(BW + 1);

    state_e              r_state;
    logic [4*NDIG-1:0]   r_bcd_sr;
    logic [BW-1:0]       r_bin_sr;
    logic [CNT_W-1:0]    r_cnt;
    logic [BW-1:0]       r_bin_out;
    logic                r_busy;
    logic                r_done;
    logic                r_err;

    logic [4*NDIG-1:0]   w_bcd_shift;
    logic [4*NDIG-1:0]   w_bcd_adj;
    logic [BW-1:0]       w_bin_shift;
    logic [NDIG-1:0]     w_dig_bad;
    logic                w_any_bad;

    // {bcd_sr, bin_sr} shifted right as one long register
    assign w_bcd_shift = r_bcd_sr >> 1;
    assign w_bin_shift = {r_bcd_sr[0], r_bin_sr[BW-1:1]};

    for (genvar g = 0; g < NDIG; g++) begin : g_dig
        bcd_digit_adj u_adj (
            .i_dig (w_bcd_shift[g*DIG_W +: DIG_W]),
            .o_dig (w_bcd_adj[g*DIG_W +: DIG_W])
        );
        assign w_dig_bad[g] = (bus.bcd_in[g*DIG_W +: DIG_W] > MAX_DIGIT);
    end

    assign w_any_bad = |w_dig_bad;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state   <= IDLE;
            r_bcd_sr  <= '0;
            r_bin_sr  <= '0;
            r_cnt     <= '0;
            r_bin_out <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        if (w_any_bad) begin
                            r_done <= 1'b1;
                            r_err  <= 1'b1;
                        end else begin
                            r_bcd_sr <= bus.bcd_in;
                            r_bin_sr <= '0;
                            r_cnt    <= CNT_W'(BW);
                            r_busy   <= 1'b1;
                            r_state  <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    r_bcd_sr <= w_bcd_adj;
                    r_bin_sr <= w_bin_shift;
                    r_cnt    <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_bin_out <= w_bin_shift;
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.bin_out = r_bin_out;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.err     = r_err;
    assign o_state     = r_state;
endmodule

// File: tb/tb_bcd_to_bin.sv
// Directed bench for bcd_to_bin: a 4-digit and a 2-digit instance, each with
// an expected-result queue drained by its own monitor on the falling edge.
module tb_bcd_to_bin;
    import bcd_pkg::*;

    localparam int BW4 = 14;
    localparam int BW2 = 7;

    typedef struct {
        logic [13:0] bin;
        logic        err;
        int          due;
    } exp_t;

    logic   clk = 1'b0;
    logic   clr = 1'b1;
    int     cyc = 0;
    int     n_tests = 0;
    int     n_fail = 0;
    int     busy_run4 = 0;
    int     busy_run2 = 0;
    exp_t   exp_q[$];
    exp_t   exp2_q[$];
    state_e state4;
    state_e state2;

    bcd_to_bin_if #(.NDIG(4), .BW(BW4)) bus4 ();
    bcd_to_bin_if #(.NDIG(2), .BW(BW2)) bus2 ();

    bcd_to_bin #(.NDIG(4), .BW(BW4)) u_dut4 (
        .clk     (clk),
        .clr     (clr),
        .bus     (bus4),
        .o_state (state4)
    );

    bcd_to_bin #(.NDIG(2), .BW(BW2)) u_dut2 (
        .clk     (clk),
        .clr     (clr),
        .bus     (bus2),
        .o_state (state2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Pulse start for one cycle; the accepting edge is the next posedge.
    task automatic issue4(input logic [15:0] v, input logic [13:0] eb, input logic ee, input bit push);
        exp_t e;
        @(negedge clk);
        bus4.start  = 1'b1;
        bus4.bcd_in = v;
        e.bin = eb;
        e.err = ee;
        e.due = cyc + 1 + (ee ? 0 : BW4);
        if (push) exp_q.push_back(e);
        @(negedge clk);
        bus4.start  = 1'b0;
        bus4.bcd_in = 16'($urandom_range(0, 65535));
    endtask

    task automatic issue2(input logic [7:0] v, input logic [6:0] eb);
        exp_t e;
        @(negedge clk);
        bus2.start  = 1'b1;
        bus2.bcd_in = v;
        e.bin = {7'd0, eb};
        e.err = 1'b0;
        e.due = cyc + 1 + BW2;
        exp2_q.push_back(e);
        @(negedge clk);
        bus2.start  = 1'b0;
        bus2.bcd_in = 8'($urandom_range(0, 255));
    endtask

    task automatic drain(input int budget);
        int i;
        i = 0;
        while ((exp_q.size() != 0 || exp2_q.size() != 0) && i < budget) begin
            @(negedge clk);
            i++;
        end
        check("drain_timeout", exp_q.size() + exp2_q.size(), 0);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (clr) begin
            busy_run4 <= 0;
        end else if (bus4.done) begin
            check("busy_done_excl4", {31'd0, bus4.busy}, 0);
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done4: got done=1 expected no result (cycle %0d)", cyc);
            end else begin
                e = exp_q.pop_front();
                check("bin_out4", {18'd0, bus4.bin_out}, {18'd0, e.bin});
                check("err4", {31'd0, bus4.err}, {31'd0, e.err});
                check("latency4", cyc, e.due);
                check("busy_cycles4", busy_run4, e.err ? 0 : BW4);
            end
            busy_run4 <= 0;
        end else if (bus4.busy) begin
            busy_run4 <= busy_run4 + 1;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (clr) begin
            busy_run2 <= 0;
        end else if (bus2.done) begin
            if (exp2_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done2: got done=1 expected no result (cycle %0d)", cyc);
            end else begin
                e = exp2_q.pop_front();
                check("bin_out2", {25'd0, bus2.bin_out}, {18'd0, e.bin});
                check("err2", {31'd0, bus2.err}, 0);
                check("latency2", cyc, e.due);
                check("busy_cycles2", busy_run2, BW2);
            end
            busy_run2 <= 0;
        end else if (bus2.busy) begin
            busy_run2 <= busy_run2 + 1;
        end
    end

    initial begin
        bus4.start  = 1'b0;
        bus4.bcd_in = '0;
        bus2.start  = 1'b0;
        bus2.bcd_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        clr = 1'b0;

        check("rst_bin_out", {18'd0, bus4.bin_out}, 0);
        check("rst_busy", {31'd0, bus4.busy}, 0);
        check("rst_done", {31'd0, bus4.done}, 0);
        check("rst_err", {31'd0, bus4.err}, 0);
        check("rst_state", {31'd0, state4}, {31'd0, IDLE});

        issue4(16'h0000, 14'd0, 1'b0, 1'b1);
        drain(40);
        issue4(16'h1234, 14'h04D2, 1'b0, 1'b1);
        drain(40);
        issue4(16'h8765, 14'h223D, 1'b0, 1'b1);
        drain(40);

        // back-to-back: second start lands in the done cycle of the first
        issue4(16'h9999, 14'h270F, 1'b0, 1'b1);
        repeat (BW4 - 1) @(negedge clk);
        issue4(16'h0001, 14'd1, 1'b0, 1'b1);
        drain(40);

        // illegal digit: error pulse, previous result held
        issue4(16'h1A34, 14'd1, 1'b1, 1'b1);
        drain(40);
        issue4(16'h000F, 14'd1, 1'b1, 1'b1);
        drain(40);

        // start during SHIFT is dropped
        issue4(16'h0500, 14'd500, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        issue4(16'h0777, 14'd0, 1'b0, 1'b0);
        drain(40);

        // clr mid-conversion: no done, outputs cleared
        issue4(16'h1234, 14'd0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("abort_bin_out", {18'd0, bus4.bin_out}, 0);
        check("abort_busy", {31'd0, bus4.busy}, 0);
        check("abort_done", {31'd0, bus4.done}, 0);
        check("abort_err", {31'd0, bus4.err}, 0);
        repeat (BW4 + 4) @(negedge clk);

        issue2(8'h99, 7'd99);
        drain(40);
        issue2(8'h42, 7'd42);
        drain(40);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/bcd_to_bin.md
# bcd_to_bin

Sequential BCD-to-binary converter, the decode side of the team's BCD counter chain. Accepts NDIG packed BCD digits (e.g. the concatenated q outputs of cascaded bcd counter stages) on a start strobe and produces the equivalent unsigned binary value using iterative reverse double-dabble, one bit per clock. Sits between the decade-counter bank and any binary consumer (comparators, accumulators, serial reporters).

## Interface
- NDIG, 4: number of BCD digits; legal range 1..8.
- BW, 14: binary result width; must satisfy 2^BW >= 10^NDIG (14 for NDIG=4, 7 for NDIG=2).
- clk  in  1  single clock, all logic on rising edge.
- clr  in  1  reset, synchronous, active-high.
- start  in  1  request a conversion of bcd_in; sampled only in IDLE.
- bcd_in  in  4*NDIG  packed digits, digit 0 (least significant) in [3:0].
- bin_out  out  BW  last successful result; held between conversions.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse ending every accepted request (success or error).
- err  out  1  one-cycle pulse with done when the request held an illegal digit.

## Operation
- States: IDLE, SHIFT.
- IDLE, start=0: hold all.
- IDLE, start=1, every digit <= 9: load bcd_sr <= bcd_in, bin_sr <= 0, cnt <= BW; go to SHIFT.
- IDLE, start=1, any digit > 9: stay IDLE; done=1, err=1 for one cycle; bin_out unchanged; busy stays 0.
- SHIFT step (each cycle): {bcd_sr, bin_sr} shifted right one bit (bcd_sr LSB enters bin_sr MSB); then every 4-bit digit of the shifted bcd_sr that is >= 8 has 3 subtracted; cnt decrements.
- Final step (cnt = 1): bin_out <= resulting bin_sr, done=1, err=0, go to IDLE.
- start while in SHIFT: ignored, not queued.
- bcd_in is only sampled at acceptance; later changes do not affect the running conversion.
- Arithmetic: digit adjust is 4-bit unsigned, never underflows (operand >= 8); bin_sr is exactly BW bits, no overflow for legal NDIG/BW.

## Timing
- Reset (clr=1 at an edge): state IDLE, bin_out=0, busy=0, done=0, err=0, cnt=0, shift registers 0.
- clr mid-conversion: aborts; no done pulse; bin_out returns to 0.
- Latency: start accepted at edge T0 -> busy=1 after T0 -> done=1, busy=0, bin_out valid after edge T0+BW (BW cycles; 14 for defaults).
- Error path latency: done/err visible after edge T0 (1 cycle).
- done, err are registered, high exactly one cycle.
- Back-to-back: start high in the done cycle (state already IDLE) is accepted; throughput one conversion per BW cycles.
- busy and done never high in the same cycle.

## Structure
- Package bcd_pkg: state enum (IDLE, SHIFT), digit width constant (4), max legal digit constant (9), adjust threshold (8) and offset (3).
- Sub-module bcd_digit_adj: combinational 4-bit "if >= 8 subtract 3" cell, instanced NDIG times in a generate loop.
- Digit-legality check (any digit > 9) is a generate-built OR reduction in the top module.
- Counter cnt width: clog2(BW+1).

## Test plan
- After clr, bcd_in=16'h0000, start 1 cycle -> busy 14 cycles, then done=1, err=0, bin_out=14'd0.
- bcd_in=16'h1234, start -> after 14 cycles bin_out=14'h04D2, done single pulse.
- bcd_in=16'h9999, start -> bin_out=14'h270F; then bcd_in=16'h0001 with start in the done cycle -> accepted, bin_out=14'd1 14 cycles later.
- bcd_in=16'h1A34, start -> next cycle done=1, err=1, busy never 1, bin_out keeps previous value.
- Start 16'h0500, re-assert start with 16'h0777 mid-conversion -> ignored, result 14'd500; then clr at cycle 5 of a new conversion -> no done, all outputs 0.
- NDIG=2, BW=7: bcd_in=8'h99 -> done after 7 cycles, bin_out=7'd99.
